// File: rtl/sort_checker_pkg.sv
// Shared definitions for the sort checker: default geometry, the frame
// state machine encoding and a helper for the histogram bin width.
package sort_checker_pkg;

    localparam int DATA_W    = 8;    // data width, histogram has 2**DATA_W bins
    localparam int DATA_NUM  = 256;  // beats per frame (power of two, 2..256)
    localparam int ERR_CNT_W = 16;   // width of the saturating order-error counter
    localparam int IDX_OUT_W = 8;    // width of the reported first-error index

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Bins swing from -DATA_NUM to +DATA_NUM, which needs clog2(DATA_NUM)+2
    // bits in two's complement without wrapping.
    function automatic int bin_width(input int data_num);
        return $clog2(data_num) + 2;
    endfunction

endpackage

// File: rtl/sort_checker_if.sv
// Data taps, control and result bundle of the sort checker. The master side
// is whatever feeds the taps (the sorter environment); the slave side is the
// checker itself.
interface sort_checker_if #(
    parameter int DATA_W = sort_checker_pkg::DATA_W
) ();

    logic [DATA_W-1:0]                        src_data;
    logic                                     src_valid;
    logic [DATA_W-1:0]                        dst_data;
    logic                                     dst_valid;
    logic                                     clear;
    logic                                     done;
    logic                                     pass;
    logic [sort_checker_pkg::ERR_CNT_W-1:0]   order_err_cnt;
    logic [sort_checker_pkg::IDX_OUT_W-1:0]   first_err_idx;
    logic [DATA_W:0]                          mismatch_cnt;
    logic                                     overrun;

    modport master (
        output src_data, src_valid, dst_data, dst_valid, clear,
        input  done, pass, order_err_cnt, first_err_idx, mismatch_cnt, overrun
    );

    modport slave (
        input  src_data, src_valid, dst_data, dst_valid, clear,
        output done, pass, order_err_cnt, first_err_idx, mismatch_cnt, overrun
    );

endinterface

// File: rtl/sort_hist.sv
// Signed histogram: the sorter input increments a bin, the sorter output
// decrements one, so a frame whose output is a permutation of its input
// leaves every bin at zero. A read port returns one bin and zeroes it on the
// same edge, so scanning the array also leaves it ready for the next frame.
module sort_hist #(
    parameter int DATA_W = 8,
    parameter int BIN_W  = 10
) (
    input  logic                    clk,
    input  logic                    i_clr,
    input  logic                    i_inc_en,
    input  logic [DATA_W-1:0]       i_inc_idx,
    input  logic                    i_dec_en,
    input  logic [DATA_W-1:0]       i_dec_idx,
    input  logic                    i_rd_en,
    input  logic [DATA_W-1:0]       i_rd_idx,
    output logic signed [BIN_W-1:0] o_rd_data
);

    localparam int NBINS = 2 ** DATA_W;
    localparam logic signed [BIN_W-1:0] ONE = BIN_W'(1);

    logic signed [BIN_W-1:0] r_bin [NBINS];
    logic [NBINS-1:0]        w_inc_hit;
    logic [NBINS-1:0]        w_dec_hit;

    assign o_rd_data = r_bin[i_rd_idx];

    // One-hot decode of the increment and decrement targets.
    // NOTE: both vectors get a full default before the conditional writes,
    // otherwise the untouched bits would hold their value and infer latches.
    always_comb begin
        w_inc_hit = '0;
        w_dec_hit = '0;
        if (i_inc_en) w_inc_hit[i_inc_idx] = 1'b1;
        if (i_dec_en) w_dec_hit[i_dec_idx] = 1'b1;
    end

    // Bin update: clear dominates, then read-and-clear, then the net of
    // increment and decrement (equal hits on one bin cancel out).
    // NOTE: the bins are ordinary flops with a synchronous clear because a
    // reset in the middle of a frame must discard every partial count; a
    // RAM-style array without reset would leave stale bins behind.
    // NOTE: state is assigned with <= so every bin samples the pre-edge
    // value of its neighbours' inputs, independent of statement order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBINS; i++) begin
            if (i_clr) begin
                r_bin[i] <= '0;
            end else if (i_rd_en && (i_rd_idx == DATA_W'(i))) begin
                r_bin[i] <= '0;
            end else if (w_inc_hit[i] && !w_dec_hit[i]) begin
                r_bin[i] <= r_bin[i] + ONE;
            end else if (w_dec_hit[i] && !w_inc_hit[i]) begin
                r_bin[i] <= r_bin[i] - ONE;
            end
        end
    end

endmodule

// File: rtl/sort_checker.sv
// Sort checker: watches the input and output taps of a sorter for one frame
// of DATA_NUM beats, checks that the output is non-decreasing and that it is
// a permutation of the input (via a signed histogram), then reports a held
// result until cleared.
module sort_checker #(
    parameter int DATA_NUM = sort_checker_pkg::DATA_NUM,
    parameter int DATA_W   = sort_checker_pkg::DATA_W
) (
    input  logic            clk,
    input  logic            xrst,
    sort_checker_if.slave   bus
);

    import sort_checker_pkg::*;

    localparam int BIN_W = bin_width(DATA_NUM);
    localparam int IDX_W = $clog2(DATA_NUM);
    localparam int SRC_W = IDX_W + 1;   // must hold DATA_NUM itself

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [SRC_W-1:0]         r_src_cnt;
    logic [IDX_W-1:0]         r_dst_cnt;
    logic [DATA_W-1:0]        r_prev_data;
    logic [DATA_W-1:0]        r_scan_idx;
    logic [ERR_CNT_W-1:0]     r_order_err_cnt;
    logic [IDX_OUT_W-1:0]     r_first_err_idx;
    logic [DATA_W:0]          r_mismatch_cnt;
    logic                     r_overrun;
    logic                     r_done;

    logic                     w_collect;
    logic                     w_scan;
    logic                     w_src_acc;
    logic                     w_dst_acc;
    logic                     w_last_dst;
    logic                     w_scan_last;
    logic                     w_order_err;
    logic                     w_rearm;
    logic signed [BIN_W-1:0]  w_rd_data;

    assign w_collect   = (r_state == COLLECT);
    assign w_scan      = (r_state == SCAN);
    assign w_src_acc   = w_collect && bus.src_valid && (r_src_cnt < SRC_W'(DATA_NUM));
    assign w_dst_acc   = w_collect && bus.dst_valid;
    assign w_last_dst  = w_dst_acc && (r_dst_cnt == IDX_W'(DATA_NUM - 1));
    assign w_scan_last = w_scan && (r_scan_idx == '1);
    assign w_order_err = w_dst_acc && (r_dst_cnt != '0) && (bus.dst_data < r_prev_data);
    assign w_rearm     = (r_state == DONE) && bus.clear;

    sort_hist #(
        .DATA_W (DATA_W),
        .BIN_W  (BIN_W)
    ) u_hist (
        .clk       (clk),
        .i_clr     (xrst),
        .i_inc_en  (w_src_acc),
        .i_inc_idx (bus.src_data),
        .i_dec_en  (w_dst_acc),
        .i_dec_idx (bus.dst_data),
        .i_rd_en   (w_scan),
        .i_rd_idx  (r_scan_idx),
        .o_rd_data (w_rd_data)
    );

    // Frame state register.
    always_ff @(posedge clk) begin
        if (xrst) r_state <= COLLECT;
        else      r_state <= w_state_nxt;
    end

    // Next state: collect a frame, scan every bin once, hold until cleared.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            COLLECT: if (w_last_dst)  w_state_nxt = SCAN;
            SCAN:    if (w_scan_last) w_state_nxt = DONE;
            DONE:    if (bus.clear)   w_state_nxt = COLLECT;
            default:                  w_state_nxt = COLLECT;
        endcase
    end

    // Beat counters, order checker, scan accumulation and result flags.
    always_ff @(posedge clk) begin
        if (xrst || w_rearm) begin
            r_src_cnt       <= '0;
            r_dst_cnt       <= '0;
            r_prev_data     <= '0;
            r_scan_idx      <= '0;
            r_order_err_cnt <= '0;
            r_first_err_idx <= '0;
            r_mismatch_cnt  <= '0;
            r_overrun       <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            if (w_src_acc) r_src_cnt <= r_src_cnt + 1'b1;

            if (w_dst_acc) begin
                r_dst_cnt   <= r_dst_cnt + 1'b1;
                r_prev_data <= bus.dst_data;
            end

            // The counter saturates rather than wrapping, so a zero count
            // always means the current frame is still free of order errors.
            if (w_order_err) begin
                if (r_order_err_cnt != '1) r_order_err_cnt <= r_order_err_cnt + 1'b1;
                if (r_order_err_cnt == '0) r_first_err_idx <= IDX_OUT_W'(r_dst_cnt);
            end

            if (w_scan) begin
                r_scan_idx <= r_scan_idx + 1'b1;
                if (w_rd_data != '0) r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end

            if (!w_collect && bus.dst_valid) r_overrun <= 1'b1;

            // Registered one edge after entering DONE so the last scanned
            // bin is already folded into mismatch_cnt when done rises.
            r_done <= (r_state == DONE);
        end
    end

    assign bus.done          = r_done;
    assign bus.pass          = r_done && (r_order_err_cnt == '0) &&
                               (r_mismatch_cnt == '0) && !r_overrun;
    assign bus.order_err_cnt = r_order_err_cnt;
    assign bus.first_err_idx = r_first_err_idx;
    assign bus.mismatch_cnt  = r_mismatch_cnt;
    assign bus.overrun       = r_overrun;

endmodule

// File: tb/tb_sort_checker.sv
// Directed bench for sort_checker at default geometry (256 beats, 8 bits).
module tb_sort_checker;

    logic clk = 1'b0;
    logic xrst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sort_checker_if #(.DATA_W(8)) bus ();

    sort_checker #(
        .DATA_NUM (256),
        .DATA_W   (8)
    ) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then idle the strobes.
    task automatic cyc(input logic sv, input logic [7:0] sd,
                       input logic dv, input logic [7:0] dd, input logic clr);
        bus.src_valid = sv;
        bus.src_data  = sd;
        bus.dst_valid = dv;
        bus.dst_data  = dd;
        bus.clear     = clr;
        @(posedge clk);
        #1;
        bus.src_valid = 1'b0;
        bus.dst_valid = 1'b0;
        bus.clear     = 1'b0;
    endtask

    // Count edges from now until done is seen, bounded.
    task automatic wait_done(input string tag, input int exp_edges);
        int n = 0;
        while (bus.done !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done_latency"}, 32'(n), 32'(exp_edges));
    endtask

    task automatic check_result(input string tag, input logic exp_pass, input int exp_err,
                                input int exp_first, input int exp_mis, input logic exp_ovr);
        check({tag, "_done"},      32'(bus.done),          32'd1);
        check({tag, "_pass"},      32'(bus.pass),          32'(exp_pass));
        check({tag, "_order_err"}, 32'(bus.order_err_cnt), 32'(exp_err));
        check({tag, "_first_idx"}, 32'(bus.first_err_idx), 32'(exp_first));
        check({tag, "_mismatch"},  32'(bus.mismatch_cnt),  32'(exp_mis));
        check({tag, "_overrun"},   32'(bus.overrun),       32'(exp_ovr));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"},      32'(bus.done),          32'd0);
        check({tag, "_pass"},      32'(bus.pass),          32'd0);
        check({tag, "_order_err"}, 32'(bus.order_err_cnt), 32'd0);
        check({tag, "_first_idx"}, 32'(bus.first_err_idx), 32'd0);
        check({tag, "_mismatch"},  32'(bus.mismatch_cnt),  32'd0);
        check({tag, "_overrun"},   32'(bus.overrun),       32'd0);
    endtask

    task automatic do_clear(input string tag);
        cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        check_idle({tag, "_clr"});
    endtask

    // Sorted frame with src and dst beats to the same bin in the same cycle.
    task automatic clean_frame();
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b1, 8'(i), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int seen;
        logic [7:0] d;

        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.dst_valid = 1'b0;
        bus.dst_data  = '0;
        bus.clear     = 1'b0;
        xrst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        xrst = 1'b0;

        // Sorted identity frame; result must hold while waiting in DONE.
        clean_frame();
        wait_done("t1", 257);
        check_result("t1", 1'b1, 0, 0, 0, 1'b0);
        repeat (5) cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        check_result("t1_hold", 1'b1, 0, 0, 0, 1'b0);
        do_clear("t1");

        // Scrambled input (i*97+13 is a permutation of 0..255); output sorted
        // except beats 9 and 10 exchanged, so the only descent is at beat 10.
        // A clear pulse during COLLECT must be ignored.
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'((i * 97 + 13) & 255), 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            d = 8'(i);
            if (i == 9)  d = 8'd10;
            if (i == 10) d = 8'd9;
            cyc(1'b0, 8'd0, 1'b1, d, (i == 200));
        end
        wait_done("t2", 257);
        check_result("t2", 1'b0, 1, 10, 0, 1'b0);
        do_clear("t2");

        // Fully descending output: every beat after the first is an error.
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b1, 8'(255 - i), 1'b0);
        wait_done("t2b", 257);
        check_result("t2b", 1'b0, 255, 1, 0, 1'b0);
        do_clear("t2b");

        // All-0x05 input, output ends on 0x06: bins 5 and 6 both off by one.
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'd5, 1'b1, (i == 255) ? 8'd6 : 8'd5, 1'b0);
        wait_done("t3", 257);
        check_result("t3", 1'b0, 0, 0, 2, 1'b0);
        do_clear("t3");

        // 256 repeated input frames; only the first 256 src beats may count.
        for (int i = 0; i < 65280; i++) cyc(1'b1, 8'(i & 255), 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 256; i++)   cyc(1'b1, 8'(i), 1'b1, 8'(i), 1'b0);
        wait_done("t4", 257);
        check_result("t4", 1'b1, 0, 0, 0, 1'b0);
        do_clear("t4");

        // dst beat during SCAN: overrun, and bin 0xFF must not be touched.
        clean_frame();
        repeat (10) cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 8'hFF, 1'b0);
        check("t5_overrun_sticky", 32'(bus.overrun), 32'd1);
        wait_done("t5", 246);
        check_result("t5", 1'b0, 0, 0, 0, 1'b1);
        do_clear("t5");
        clean_frame();
        wait_done("t5b", 257);
        check_result("t5b", 1'b1, 0, 0, 0, 1'b0);
        do_clear("t5b");

        // Reset after 100 beats, with clear and beats asserted in the same
        // cycle; the partial frame must vanish and never produce done.
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i), 1'b1, 8'(i), 1'b0);
        xrst = 1'b1;
        cyc(1'b1, 8'h80, 1'b1, 8'h80, 1'b1);
        xrst = 1'b0;
        check_idle("t6_rst");
        seen = 0;
        repeat (300) begin
            cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
            if (bus.done === 1'b1) seen++;
        end
        check("t6_no_done", 32'(seen), 32'd0);
        clean_frame();
        wait_done("t6", 257);
        check_result("t6", 1'b1, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
